horizontal_timing: RTL and testbench

- Upstream stage of the vertical line counter in the 800x600@72 Hz display timing chain (50 MHz pixel rate).
- Generates the horizontal pixel count (`Hcnt`), horizontal sync and horizontal active signals.
- Issues a one-clock terminal-count strobe `tc` at each line end; the vertical counter consumes `tc` to advance `Vcnt` (0..665, 666 lines).
- Includes a pixel-rate prescaler and a run/drain controller, so the line always completes before the counter parks.

---
 rtl/t03_timing_pkg.sv | 28 ++
 rtl/horizontal_timing_prescaler.sv | 28 ++
 rtl/horizontal_timing.sv | 91 +++++++++
 tb/tb_horizontal_timing.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/t03_timing_pkg.sv
// Shared timing constants and types for the 800x600@72 Hz display timing chain.
package t03_timing_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 56;
    localparam int H_SYNC   = 120;
    localparam int H_BP     = 64;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = 666;

    typedef logic [10:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } htim_state_t;

    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t HS_FIRST   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_LAST    = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t ACT_LIMIT  = cnt_t'(H_ACTIVE);

    function automatic logic in_sync(input cnt_t h);
        return (h >= HS_FIRST) && (h <= HS_LAST);
    endfunction

endpackage

// File: rtl/horizontal_timing_prescaler.sv
// Modulo-CLK_DIV pixel prescaler; tick marks the last clk of each pixel period.
module pixel_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/horizontal_timing.sv
// Horizontal pixel counter with sync/active generation and a run/drain controller
// that always finishes the current line before parking.
module horizontal_timing
    import t03_timing_pkg::*;
#(
    parameter int CLK_DIV   = 1,
    parameter bit HSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [10:0] Hcnt,
    output logic        tc,
    output logic        hsync,
    output logic        h_active,
    output logic        line_start,
    output logic        busy
);

    htim_state_t state_q, state_d;
    cnt_t        hcnt_q, hcnt_d;
    logic        hsync_q, hsync_d;
    logic        h_active_q, h_active_d;
    logic        line_start_q, line_start_d;
    logic        tick, wrap;

    pixel_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign wrap = tick && (hcnt_q == H_LAST);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                if (run) state_d = RUN;
            end
            RUN: begin
                if (tick) hcnt_d = wrap ? '0 : hcnt_q + 1'b1;
                if (!run) state_d = DRAIN;
            end
            DRAIN: begin
                if (tick) hcnt_d = wrap ? '0 : hcnt_q + 1'b1;
                // A re-raised run wins over the wrap so the next line is not lost.
                if (run)       state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    // Derived outputs look at next-state values so they line up with Hcnt.
    always_comb begin
        line_start_d = (state_d != IDLE) && ((state_q == IDLE) || wrap);
        h_active_d   = (state_d != IDLE) && (hcnt_d < ACT_LIMIT);
        hsync_d      = ((state_d != IDLE) && in_sync(hcnt_d)) ? HSYNC_POL : ~HSYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            hsync_q      <= ~HSYNC_POL;
            h_active_q   <= 1'b0;
            line_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            hsync_q      <= hsync_d;
            h_active_q   <= h_active_d;
            line_start_q <= line_start_d;
        end
    end

    assign Hcnt       = hcnt_q;
    assign tc         = (state_q != IDLE) && wrap;
    assign hsync      = hsync_q;
    assign h_active   = h_active_q;
    assign line_start = line_start_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_horizontal_timing.sv
// Bench for horizontal_timing: three parameterizations checked every cycle against a
// line-position reference model, plus a vector table and hand-written corner sequences.
module tb_horizontal_timing;

    localparam int NI = 3;
    localparam int DIV [NI] = '{1, 2, 1};
    localparam bit POL [NI] = '{1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [NI];
    logic        run [NI];
    logic [10:0] hc  [NI];
    logic        tc  [NI], hs [NI], ha [NI], ls [NI], bz [NI];

    horizontal_timing #(.CLK_DIV(1), .HSYNC_POL(1'b1)) u0 (
        .clk(clk), .rst(rst[0]), .run(run[0]), .Hcnt(hc[0]), .tc(tc[0]),
        .hsync(hs[0]), .h_active(ha[0]), .line_start(ls[0]), .busy(bz[0]));
    horizontal_timing #(.CLK_DIV(2), .HSYNC_POL(1'b1)) u1 (
        .clk(clk), .rst(rst[1]), .run(run[1]), .Hcnt(hc[1]), .tc(tc[1]),
        .hsync(hs[1]), .h_active(ha[1]), .line_start(ls[1]), .busy(bz[1]));
    horizontal_timing #(.CLK_DIV(1), .HSYNC_POL(1'b0)) u2 (
        .clk(clk), .rst(rst[2]), .run(run[2]), .Hcnt(hc[2]), .tc(tc[2]),
        .hsync(hs[2]), .h_active(ha[2]), .line_start(ls[2]), .busy(bz[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position in clks since line start; a line is 1040*DIV clks.
    bit mb [NI];   // busy
    bit md [NI];   // run was seen low while busy (stop pending)
    bit mls[NI];
    int pos[NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int len;
            bit last;
            len  = 1040 * DIV[i];
            last = (pos[i] == len - 1);
            if (rst[i]) begin
                mb[i] = 0; md[i] = 0; pos[i] = 0; mls[i] = 0;
            end else if (!mb[i]) begin
                mls[i] = run[i];
                if (run[i]) begin mb[i] = 1; md[i] = 0; pos[i] = 0; end
            end else if (last && md[i] && !run[i]) begin
                mb[i] = 0; pos[i] = 0; mls[i] = 0; md[i] = 0;
            end else begin
                pos[i] = last ? 0 : pos[i] + 1;
                mls[i] = last;
                md[i]  = !run[i];
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                int h;
                bit etc, ehs, eha;
                h   = mb[i] ? pos[i] / DIV[i] : 0;
                etc = mb[i] && (pos[i] == 1040 * DIV[i] - 1);
                eha = mb[i] && (h < 800);
                ehs = (mb[i] && h >= 856 && h <= 975) ? POL[i] : !POL[i];
                n_cmp++;
                if (hc[i] != 11'(h) || tc[i] != etc || hs[i] != ehs || ha[i] != eha ||
                    ls[i] != mls[i] || bz[i] != mb[i]) begin
                    n_bad++;
                    $display("FAIL model[%0d] t=%0t got H=%0d tc=%b hs=%b ha=%b ls=%b busy=%b want H=%0d tc=%b hs=%b ha=%b ls=%b busy=%b",
                             i, $time, hc[i], tc[i], hs[i], ha[i], ls[i], bz[i],
                             h, etc, ehs, eha, mls[i], mb[i]);
                end
            end
        end
    end

    typedef struct {
        bit rst, run;
        int cyc;
        int h;
        bit busy, tc, hs, ha, ls;
    } vec_t;

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s got %s want %s", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int vcnt, ntc, c_hs[NI], c_ha, c_ls, c_tc[NI];

    initial begin
        vec_t tbl [$];
        for (int i = 0; i < NI; i++) begin rst[i] = 1'b1; run[i] = 1'b0; end
        cycles(3);
        chk_en = 1;
        for (int i = 0; i < NI; i++)
            check($sformatf("reset[%0d]", i),
                  hc[i] == 0 && !tc[i] && hs[i] == !POL[i] && !ha[i] && !ls[i] && !bz[i],
                  $sformatf("H=%0d hs=%b busy=%b", hc[i], hs[i], bz[i]),
                  $sformatf("H=0 hs=%b busy=0", !POL[i]));
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        cycles(20);
        check("idle_hold", hc[0] == 0 && !bz[0] && !ls[0], $sformatf("H=%0d busy=%b", hc[0], bz[0]), "H=0 busy=0");

        //                 rst run  cyc    H   busy tc hs ha ls
        tbl.push_back('{0, 1,    1,    0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1,  400,  400, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0,    1,  401, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0,  455,  856, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 0,  183, 1039, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0,    1,    0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1,    1,    0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1,  900,  900, 1, 0, 1, 0, 0});
        tbl.push_back('{1, 1,    1,    0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0,    5,    0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1,    1,    0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1,  400,  400, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0,  100,  500, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1,  539, 1039, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0,    1,    0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 1039, 1039, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0,    1,    0, 0, 0, 0, 0, 0});
        foreach (tbl[k]) begin
            rst[0] = tbl[k].rst;
            run[0] = tbl[k].run;
            cycles(tbl[k].cyc);
            check($sformatf("vec%0d", k),
                  hc[0] == 11'(tbl[k].h) && bz[0] == tbl[k].busy && tc[0] == tbl[k].tc &&
                  hs[0] == tbl[k].hs && ha[0] == tbl[k].ha && ls[0] == tbl[k].ls,
                  $sformatf("H=%0d busy=%b tc=%b hs=%b ha=%b ls=%b", hc[0], bz[0], tc[0], hs[0], ha[0], ls[0]),
                  $sformatf("H=%0d busy=%b tc=%b hs=%b ha=%b ls=%b", tbl[k].h, tbl[k].busy, tbl[k].tc,
                            tbl[k].hs, tbl[k].ha, tbl[k].ls));
        end
        rst[0] = 1'b0; run[0] = 1'b0;

        // Reset raised between edges must not act until the next posedge.
        run[0] = 1'b1;
        cycles(901);
        rst[0] = 1'b1;
        #2;
        check("rst_before_edge", hc[0] == 900 && bz[0] && hs[0], $sformatf("H=%0d busy=%b", hc[0], bz[0]), "H=900 busy=1");
        @(posedge clk); #1;
        check("rst_after_edge", hc[0] == 0 && !bz[0] && !tc[0] && !hs[0] && !ha[0],
              $sformatf("H=%0d busy=%b tc=%b hs=%b", hc[0], bz[0], tc[0], hs[0]), "H=0 busy=0 tc=0 hs=0");
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin rst[i] = 1'b1; run[i] = 1'b0; end
        cycles(1);

        // Window widths over 4160 clks from a common start.
        for (int i = 0; i < NI; i++) begin rst[i] = 1'b0; run[i] = 1'b1; c_hs[i] = 0; c_tc[i] = 0; end
        c_ha = 0; c_ls = 0;
        for (int k = 0; k < 4160; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (hs[i] == POL[i]) c_hs[i]++;
                if (tc[i]) c_tc[i]++;
            end
            if (ha[0]) c_ha++;
            if (ls[0]) c_ls++;
        end
        check("hsync_u0", c_hs[0] == 480, $sformatf("%0d", c_hs[0]), "480");
        check("hsync_u1", c_hs[1] == 480, $sformatf("%0d", c_hs[1]), "480");
        check("hsync_u2_neg", c_hs[2] == 480, $sformatf("%0d", c_hs[2]), "480");
        check("hactive_u0", c_ha == 3200, $sformatf("%0d", c_ha), "3200");
        check("lstart_u0", c_ls == 4, $sformatf("%0d", c_ls), "4");
        check("tc_u0", c_tc[0] == 4, $sformatf("%0d", c_tc[0]), "4");
        check("tc_u1_div2", c_tc[1] == 2, $sformatf("%0d", c_tc[1]), "2");

        // Vertical stage driven by tc.
        vcnt = 0; ntc = 0;
        for (int k = 0; k < 20 * 1040; k++) begin
            @(negedge clk);
            if (tc[0]) begin ntc++; vcnt = (vcnt == 665) ? 0 : vcnt + 1; end
        end
        check("vchain_tc", ntc == 20 && vcnt == 20, $sformatf("tc=%0d V=%0d", ntc, vcnt), "tc=20 V=20");

        // Randomized run toggling with rare resets.
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                rst[i] = ($urandom_range(0, 4999) == 0);
                if ($urandom_range(0, 399) == 0) run[i] = !run[i];
            end
        end
        for (int i = 0; i < NI; i++) begin rst[i] = 1'b0; run[i] = 1'b0; end
        cycles(2 * 2080 + 4);
        for (int i = 0; i < NI; i++)
            check($sformatf("parked[%0d]", i), !bz[i] && hc[i] == 0, $sformatf("busy=%b H=%0d", bz[i], hc[i]), "busy=0 H=0");

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
